// File: rtl/dds_multi_core.sv
// Multi-channel DDS register sequencer for AD995x-family parts.
// It pulses the part's master reset, then programs CSR, FR1 and CFR.
// After that, each update request writes only the channels whose tuning
// words changed since the last IO update.
// Optional macro DDS_PHASE_EN: adds per-channel POW tracking and CPOW0 writes.
module dds_multi_core #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FTW_W       = 32,
    parameter int unsigned ASF_W       = 10,
    parameter int unsigned POW_W       = 14,
    parameter int unsigned RST_PULSE   = 4,
    parameter int unsigned IOUPD_PULSE = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CH*FTW_W-1:0] ftw_flat,
    input  logic [NUM_CH*ASF_W-1:0] asf_flat,
    input  logic [NUM_CH*POW_W-1:0] pow_flat,
    input  logic                    vco_gain,
    input  logic [4:0]              clock_multiplier,
    input  logic [1:0]              dac_fscale,
    input  logic                    update_req,
    input  logic                    busy,
    output logic                    trigger,
    output logic [4:0]              packs_to_send,
    output logic [63:0]             data_input,
    output logic                    master_reset,
    output logic                    io_update,
    output logic                    init_done,
    output logic                    seq_done
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PMAX   = (RST_PULSE > IOUPD_PULSE) ? RST_PULSE : IOUPD_PULSE;
    localparam int unsigned CNT_W  = $clog2(PMAX + 1);
    localparam int unsigned EN_LSB = 8 - NUM_CH;
    localparam logic [7:0]  CSR_ALL = 8'h06 | 8'(((1 << NUM_CH) - 1) << EN_LSB);

    typedef enum logic [3:0] {
        ST_RST,
        ST_INIT_CSR,
        ST_INIT_FR1,
        ST_INIT_CFR,
        ST_IOUPD,
        ST_DONE,
        ST_IDLE,
        ST_SCAN,
        ST_SEL,
        ST_CH_CSR,
        ST_CH_FTW,
        ST_CH_ACR,
        ST_WAIT
`ifdef DDS_PHASE_EN
        , ST_CH_POW
`endif
    } state_t;

    state_t                 r_state, w_state_nxt;
    state_t                 r_ret, w_ret_nxt;
    logic                   r_phase, w_phase_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]        r_ch, w_ch_nxt;
    logic [NUM_CH-1:0]      r_dirty, w_dirty_nxt;
    logic [NUM_CH-1:0]      r_ftw_chg, r_asf_chg;
    logic [NUM_CH-1:0]      w_ftw_chg, w_asf_chg, w_dirty;

    logic                   r_trigger, w_trig;
    logic [4:0]             r_packs, w_packs;
    logic [63:0]            r_data, w_data;
    logic                   r_mreset, w_mreset;
    logic                   r_ioupd, w_ioupd;
    logic                   r_init_done, w_init_done;
    logic                   r_seq_done, w_seq_done;

    logic                   r_pend;
    logic                   r_cm_valid;
    logic                   w_snap, w_scan, w_commit;
    logic [FTW_W-1:0]       r_sh_ftw [NUM_CH];
    logic [ASF_W-1:0]       r_sh_asf [NUM_CH];
    logic [FTW_W-1:0]       r_cm_ftw [NUM_CH];
    logic [ASF_W-1:0]       r_cm_asf [NUM_CH];

    logic                   w_xfer;
    logic [7:0]             w_addr;
    logic [4:0]             w_len;
    logic [63:0]            w_payload;
    state_t                 w_succ;
    state_t                 w_after_csr, w_after_ftw, w_after_acr;
    logic [7:0]             w_csr_sel;
    logic                   w_found;
    logic [CH_W-1:0]        w_sel_idx;

`ifdef DDS_PHASE_EN
    logic [NUM_CH-1:0]      r_pow_chg, w_pow_chg;
    logic [POW_W-1:0]       r_sh_pow [NUM_CH];
    logic [POW_W-1:0]       r_cm_pow [NUM_CH];
`else
    logic                   w_unused_pow;
    assign w_unused_pow = ^pow_flat;
`endif

    assign trigger       = r_trigger;
    assign packs_to_send = r_packs;
    assign data_input    = r_data;
    assign master_reset  = r_mreset;
    assign io_update     = r_ioupd;
    assign init_done     = r_init_done;
    assign seq_done      = r_seq_done;

    // Per-channel change detection, lowest-dirty-channel pick and CSR select byte
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_csr_sel = 8'h06;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_ftw_chg[k] = !r_cm_valid || (r_sh_ftw[k] != r_cm_ftw[k]);
            w_asf_chg[k] = !r_cm_valid || (r_sh_asf[k] != r_cm_asf[k]);
`ifdef DDS_PHASE_EN
            w_pow_chg[k] = !r_cm_valid || (r_sh_pow[k] != r_cm_pow[k]);
            w_dirty[k]   = w_ftw_chg[k] | w_asf_chg[k] | w_pow_chg[k];
`else
            w_dirty[k]   = w_ftw_chg[k] | w_asf_chg[k];
`endif
            if (r_dirty[k] && !w_found) begin
                w_found   = 1'b1;
                w_sel_idx = CH_W'(k);
            end
            w_csr_sel[EN_LSB + k] = (r_ch == CH_W'(k));
        end
`ifdef DDS_PHASE_EN
        w_after_acr = r_pow_chg[r_ch] ? ST_CH_POW : ST_SEL;
`else
        w_after_acr = ST_SEL;
`endif
        w_after_ftw = r_asf_chg[r_ch] ? ST_CH_ACR : w_after_acr;
        w_after_csr = r_ftw_chg[r_ch] ? ST_CH_FTW : w_after_ftw;
    end

    // Next-state and next-output logic; register writes share one two-phase transfer path
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_dirty_nxt = r_dirty;
        w_trig      = 1'b0;
        w_packs     = r_packs;
        w_data      = r_data;
        w_mreset    = 1'b0;
        w_ioupd     = 1'b0;
        w_init_done = r_init_done;
        w_seq_done  = 1'b0;
        w_snap      = 1'b0;
        w_scan      = 1'b0;
        w_commit    = 1'b0;
        w_xfer      = 1'b0;
        w_addr      = 8'h00;
        w_len       = 5'd1;
        w_payload   = '0;
        w_succ      = ST_IDLE;

        case (r_state)
            ST_RST: begin
                w_mreset  = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(RST_PULSE - 1)) begin
                    w_state_nxt = ST_INIT_CSR;
                    w_cnt_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            ST_INIT_CSR: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h00;
                w_len     = 5'd1;
                w_payload = 64'(CSR_ALL);
                w_succ    = ST_INIT_FR1;
            end
            ST_INIT_FR1: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h01;
                w_len     = 5'd3;
                w_payload = 64'({vco_gain, clock_multiplier}) << 18;
                w_succ    = ST_INIT_CFR;
            end
            ST_INIT_CFR: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h03;
                w_len     = 5'd3;
                w_payload = 64'(dac_fscale) << 8;
                w_succ    = ST_IOUPD;
            end
            ST_IOUPD: begin
                w_ioupd   = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(IOUPD_PULSE - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DONE: begin
                if (r_init_done) begin
                    w_commit   = 1'b1;
                    w_seq_done = 1'b1;
                end else begin
                    w_init_done = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (update_req || r_pend) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_scan      = 1'b1;
                w_dirty_nxt = w_dirty;
                w_state_nxt = (w_dirty == '0) ? ST_DONE : ST_SEL;
            end
            ST_SEL: begin
                if (w_found) begin
                    w_ch_nxt    = w_sel_idx;
                    w_phase_nxt = 1'b0;
                    w_state_nxt = ST_CH_CSR;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IOUPD;
                end
            end
            ST_CH_CSR: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h00;
                w_len     = 5'd1;
                w_payload = 64'(w_csr_sel);
                w_succ    = w_after_csr;
                if (r_phase) begin
                    w_dirty_nxt[r_ch] = 1'b0;
                end
            end
            ST_CH_FTW: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h04;
                w_len     = 5'd4;
                w_payload = 64'(r_sh_ftw[r_ch]);
                w_succ    = w_after_ftw;
            end
            ST_CH_ACR: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h06;
                w_len     = 5'd3;
                w_payload = 64'(24'h001000 | 24'(r_sh_asf[r_ch]));
                w_succ    = w_after_acr;
            end
`ifdef DDS_PHASE_EN
            ST_CH_POW: begin
                w_xfer    = 1'b1;
                w_addr    = 8'h05;
                w_len     = 5'd2;
                w_payload = 64'(r_sh_pow[r_ch]);
                w_succ    = ST_SEL;
            end
`endif
            ST_WAIT: begin
                if (!r_trigger && !busy) begin
                    w_state_nxt = r_ret;
                end
            end
            default: w_state_nxt = ST_RST;
        endcase

        // Phase 0 sends the instruction byte and returns here; phase 1 sends the payload and moves on
        if (w_xfer) begin
            w_trig      = 1'b1;
            w_state_nxt = ST_WAIT;
            if (!r_phase) begin
                w_packs     = 5'd1;
                w_data      = 64'({1'b0, w_addr[6:0]});
                w_ret_nxt   = r_state;
                w_phase_nxt = 1'b1;
            end else begin
                w_packs     = w_len;
                w_data      = w_payload;
                w_ret_nxt   = w_succ;
                w_phase_nxt = 1'b0;
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RST;
            r_ret       <= ST_RST;
            r_phase     <= 1'b0;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_dirty     <= '0;
            r_trigger   <= 1'b0;
            r_packs     <= '0;
            r_data      <= '0;
            r_mreset    <= 1'b0;
            r_ioupd     <= 1'b0;
            r_init_done <= 1'b0;
            r_seq_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ch        <= w_ch_nxt;
            r_dirty     <= w_dirty_nxt;
            r_trigger   <= w_trig;
            r_packs     <= w_packs;
            r_data      <= w_data;
            r_mreset    <= w_mreset;
            r_ioupd     <= w_ioupd;
            r_init_done <= w_init_done;
            r_seq_done  <= w_seq_done;
        end
    end

    // Request pending flag, shadow snapshot, change flags and committed copy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= 1'b0;
            r_cm_valid <= 1'b0;
            r_ftw_chg  <= '0;
            r_asf_chg  <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_sh_ftw[k] <= '0;
                r_sh_asf[k] <= '0;
                r_cm_ftw[k] <= '0;
                r_cm_asf[k] <= '0;
            end
`ifdef DDS_PHASE_EN
            r_pow_chg <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_sh_pow[k] <= '0;
                r_cm_pow[k] <= '0;
            end
`endif
        end else begin
            if (w_snap) begin
                r_pend <= 1'b0;
            end else if (update_req) begin
                r_pend <= 1'b1;
            end
            if (w_scan) begin
                r_ftw_chg <= w_ftw_chg;
                r_asf_chg <= w_asf_chg;
`ifdef DDS_PHASE_EN
                r_pow_chg <= w_pow_chg;
`endif
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (w_snap) begin
                    r_sh_ftw[k] <= ftw_flat[k*FTW_W +: FTW_W];
                    r_sh_asf[k] <= asf_flat[k*ASF_W +: ASF_W];
`ifdef DDS_PHASE_EN
                    r_sh_pow[k] <= pow_flat[k*POW_W +: POW_W];
`endif
                end
                if (w_commit) begin
                    r_cm_ftw[k] <= r_sh_ftw[k];
                    r_cm_asf[k] <= r_sh_asf[k];
`ifdef DDS_PHASE_EN
                    r_cm_pow[k] <= r_sh_pow[k];
`endif
                end
            end
            if (w_commit) begin
                r_cm_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dds_multi_core.sv
// Scoreboard bench for dds_multi_core (NUM_CH=2): expected serial transactions
// are queued as stimulus is issued; a monitor pops and compares on each trigger.
module tb_dds_multi_core;

    localparam int NUM_CH = 2;
    localparam int FTW_W  = 32;
    localparam int ASF_W  = 10;
    localparam int POW_W  = 14;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [NUM_CH*FTW_W-1:0] ftw_flat;
    logic [NUM_CH*ASF_W-1:0] asf_flat;
    logic [NUM_CH*POW_W-1:0] pow_flat;
    logic                    vco_gain;
    logic [4:0]              clock_multiplier;
    logic [1:0]              dac_fscale;
    logic                    update_req;
    logic                    busy;
    logic                    trigger;
    logic [4:0]              packs_to_send;
    logic [63:0]             data_input;
    logic                    master_reset;
    logic                    io_update;
    logic                    init_done;
    logic                    seq_done;

    always #5 clock = ~clock;

    dds_multi_core #(
        .NUM_CH(NUM_CH), .FTW_W(FTW_W), .ASF_W(ASF_W), .POW_W(POW_W),
        .RST_PULSE(4), .IOUPD_PULSE(2)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ftw_flat(ftw_flat), .asf_flat(asf_flat), .pow_flat(pow_flat),
        .vco_gain(vco_gain), .clock_multiplier(clock_multiplier), .dac_fscale(dac_fscale),
        .update_req(update_req), .busy(busy),
        .trigger(trigger), .packs_to_send(packs_to_send), .data_input(data_input),
        .master_reset(master_reset), .io_update(io_update),
        .init_done(init_done), .seq_done(seq_done)
    );

    // Serial engine model: busy for three cycles after each trigger
    int unsigned busy_cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)          busy_cnt <= 0;
        else if (trigger)      busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_cnt != 0);

    typedef struct {
        logic [4:0]  packs;
        logic [63:0] data;
    } xact_t;
    xact_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_trig, n_mrst, n_iou, n_iou_cyc, n_seq;
    logic iou_q = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    task automatic push_write(input logic [7:0] addr, input logic [4:0] len, input logic [63:0] payload);
        exp_q.push_back('{packs: 5'd1, data: 64'(addr)});
        exp_q.push_back('{packs: len, data: payload});
    endtask

    task automatic exp_init();
        push_write(8'h00, 5'd1, 64'hC6);
        push_write(8'h01, 5'd3, 64'hD00000);
        push_write(8'h03, 5'd3, 64'h000300);
    endtask

    task automatic exp_ch(input logic [7:0] csr, input bit do_ftw, input logic [31:0] ftw,
                          input bit do_asf, input logic [23:0] acr, input bit do_pow);
        push_write(8'h00, 5'd1, 64'(csr));
        if (do_ftw) push_write(8'h04, 5'd4, 64'(ftw));
        if (do_asf) push_write(8'h06, 5'd3, 64'(acr));
`ifdef DDS_PHASE_EN
        if (do_pow) push_write(8'h05, 5'd2, 64'h0);
`else
        if (do_pow) begin end
`endif
    endtask

    // Monitor: compare every transaction and count pulse-type events
    always @(negedge clock) begin
        if (reset_n) begin
            if (trigger) begin
                n_trig++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_trigger: got packs=%0d data=0x%0h, expected no transaction",
                             packs_to_send, data_input);
                end else begin
                    xact_t e;
                    e = exp_q.pop_front();
                    chk("xact_packs", 64'(packs_to_send), 64'(e.packs));
                    chk("xact_data", data_input, e.data);
                end
            end
            if (master_reset) n_mrst++;
            if (io_update) begin
                n_iou_cyc++;
                if (!iou_q) n_iou++;
            end
            iou_q = io_update;
            if (seq_done) n_seq++;
        end else begin
            iou_q = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        n_trig = 0; n_mrst = 0; n_iou = 0; n_iou_cyc = 0; n_seq = 0;
    endtask

    task automatic pulse_req();
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [31:0] ftw, input logic [9:0] asf);
        ftw_flat[k*FTW_W +: FTW_W] = ftw;
        asf_flat[k*ASF_W +: ASF_W] = asf;
    endtask

    task automatic wait_init(input int bound);
        for (int i = 0; i < bound && !init_done; i++) tick();
        chk("init_done", 64'(init_done), 64'd1);
    endtask

    task automatic wait_seq(input int target, input int bound);
        for (int i = 0; i < bound && n_seq < target; i++) tick();
        chk("seq_done_count", 64'(n_seq), 64'(target));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_trigger"}, 64'(trigger), 64'd0);
        chk({tag, "_packs"}, 64'(packs_to_send), 64'd0);
        chk({tag, "_data"}, data_input, 64'd0);
        chk({tag, "_master_reset"}, 64'(master_reset), 64'd0);
        chk({tag, "_io_update"}, 64'(io_update), 64'd0);
        chk({tag, "_init_done"}, 64'(init_done), 64'd0);
        chk({tag, "_seq_done"}, 64'(seq_done), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  got;

        reset_n = 1'b1; update_req = 1'b0;
        ftw_flat = '0; asf_flat = '0; pow_flat = '0;
        vco_gain = 1'b1; clock_multiplier = 5'd20; dac_fscale = 2'd3;
        clr();
        #2 reset_n = 1'b0;
        #1;
        chk_outputs_zero("reset");

        // 1: initialisation sequence
        exp_init();
        repeat (3) tick();
        clr();
        reset_n = 1'b1;
        wait_init(400);
        tick();
        chk("init_mreset_cycles", 64'(n_mrst), 64'd4);
        chk("init_ioupd_pulses", 64'(n_iou), 64'd1);
        chk("init_ioupd_cycles", 64'(n_iou_cyc), 64'd2);
        chk("init_triggers", 64'(n_trig), 64'd6);
        chk("init_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: first update writes both channels
        set_ch(0, 32'h12345678, 10'h3FF);
        set_ch(1, 32'h0ABCDEF0, 10'h155);
        clr();
        exp_ch(8'h46, 1'b1, 32'h12345678, 1'b1, 24'h0013FF, 1'b1);
        exp_ch(8'h86, 1'b1, 32'h0ABCDEF0, 1'b1, 24'h001155, 1'b1);
        pulse_req();
        wait_seq(1, 600);
        chk("upd1_ioupd_pulses", 64'(n_iou), 64'd1);
        chk("upd1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: only ch1 ASF changes
        set_ch(1, 32'h0ABCDEF0, 10'h200);
        clr();
        exp_ch(8'h86, 1'b0, 32'h0, 1'b1, 24'h001200, 1'b0);
        pulse_req();
        wait_seq(1, 600);
        chk("asf_only_triggers", 64'(n_trig), 64'd4);
        chk("asf_only_ioupd_pulses", 64'(n_iou), 64'd1);
        chk("asf_only_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: no change -> empty sequence
        clr();
        update_req = 1'b1;
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            update_req = 1'b0;
            cyc++;
            if (seq_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("empty_seq_done_seen", 64'(got), 64'd1);
        chk("empty_seq_latency_within_bound", 64'(cyc <= NUM_CH + 2), 64'd1);
        repeat (5) tick();
        chk("empty_triggers", 64'(n_trig), 64'd0);
        chk("empty_ioupd_pulses", 64'(n_iou), 64'd0);

        // 5: two requests during a sequence merge into one follow-up sequence
        set_ch(0, 32'h11111111, 10'h3FF);
        clr();
        exp_ch(8'h46, 1'b1, 32'h11111111, 1'b0, 24'h0, 1'b0);
        exp_ch(8'h46, 1'b1, 32'h22222222, 1'b0, 24'h0, 1'b0);
        exp_ch(8'h86, 1'b1, 32'h33333333, 1'b0, 24'h0, 1'b0);
        pulse_req();
        repeat (8) tick();
        set_ch(0, 32'h22222222, 10'h3FF);
        pulse_req();
        repeat (2) tick();
        set_ch(1, 32'h33333333, 10'h200);
        pulse_req();
        wait_seq(2, 800);
        repeat (30) tick();
        chk("merge_seq_count", 64'(n_seq), 64'd2);
        chk("merge_ioupd_pulses", 64'(n_iou), 64'd2);
        chk("merge_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset during the FTW write wait, re-init, request held pending
        set_ch(0, 32'h44444444, 10'h3FF);
        clr();
        exp_ch(8'h46, 1'b1, 32'h44444444, 1'b0, 24'h0, 1'b0);
        pulse_req();
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (trigger && packs_to_send == 5'd4) begin
                got = 1'b1;
                break;
            end
        end
        chk("ftw_write_seen", 64'(got), 64'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        chk("midreset_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_init();
        exp_ch(8'h46, 1'b1, 32'h44444444, 1'b1, 24'h0013FF, 1'b1);
        exp_ch(8'h86, 1'b1, 32'h33333333, 1'b1, 24'h001200, 1'b1);
        tick();
        clr();
        reset_n = 1'b1;
        pulse_req();
        wait_init(400);
        wait_seq(1, 800);
        chk("rerun_mreset_cycles", 64'(n_mrst), 64'd4);
        chk("rerun_ioupd_pulses", 64'(n_iou), 64'd2);
        chk("rerun_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
